// File: rtl/i_cache.sv
// 1 KB two-way set-associative instruction cache: 32 sets, 8 x 16-bit words per
// block, combinational lookup, single-edge write/allocate with per-set LRU.
module i_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Address,
  input  logic [15:0] Data_In,
  input  logic        Write_Enable,
  output logic [15:0] Data_Out,
  output logic        Miss
);

  logic [15:0] data_mem [2][32][8];
  logic [6:0]  tag_mem  [2][32];
  logic [31:0] valid    [2];
  logic [31:0] lru;

  logic [2:0] word_sel;
  logic [4:0] set_sel;
  logic [6:0] tag_sel;
  logic       addr_unused;

  assign word_sel    = Address[3:1];
  assign set_sel     = Address[8:4];
  assign tag_sel     = Address[15:9];
  assign addr_unused = Address[0];

  logic hit0;
  logic hit1;
  logic hit;
  logic hit_way;
  logic victim;

  always_comb begin
    hit0    = valid[0][set_sel] && (tag_mem[0][set_sel] == tag_sel);
    hit1    = valid[1][set_sel] && (tag_mem[1][set_sel] == tag_sel);
    hit     = hit0 || hit1;
    hit_way = hit1;
    // Fill empty ways in order before falling back to the LRU way.
    if (!valid[0][set_sel])
      victim = 1'b0;
    else if (!valid[1][set_sel])
      victim = 1'b1;
    else
      victim = lru[set_sel];
  end

  always_comb begin
    Miss     = ~hit;
    Data_Out = '0;
    if (hit)
      Data_Out = data_mem[hit_way][set_sel][word_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else if (Write_Enable) begin
      if (hit) begin
        data_mem[hit_way][set_sel][word_sel] <= Data_In;
        lru[set_sel] <= ~hit_way;
      end else begin
        valid[victim][set_sel]  <= 1'b1;
        tag_mem[victim][set_sel] <= tag_sel;
        for (int unsigned w = 0; w < 8; w++)
          data_mem[victim][set_sel][3'(w)] <= (3'(w) == word_sel) ? Data_In : '0;
        lru[set_sel] <= ~victim;
      end
    end else if (hit) begin
      lru[set_sel] <= ~hit_way;
    end
  end

endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: recency-ordered reference model checked every cycle, plus
// directed scenarios with literal expected values.
module tb_i_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Address;
  logic [15:0] Data_In;
  logic        Write_Enable;
  logic [15:0] Data_Out;
  logic        Miss;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  i_cache dut (
    .clk          (clk),
    .rst          (rst),
    .Address      (Address),
    .Data_In      (Data_In),
    .Write_Enable (Write_Enable),
    .Data_Out     (Data_Out),
    .Miss         (Miss)
  );

  // Model: per set, up to two blocks kept in recency order (slot 0 = most recent).
  int          m_cnt  [32];
  logic [6:0]  m_tag  [32][2];
  logic [15:0] m_data [32][2][8];

  function automatic int find(input logic [15:0] a);
    int s;
    s = int'(a[8:4]);
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_tag[s][i] == a[15:9]) return i;
    return -1;
  endfunction

  function automatic void promote(input int s, input int i);
    logic [6:0]  t;
    logic [15:0] d;
    if (i == 1) begin
      t = m_tag[s][0]; m_tag[s][0] = m_tag[s][1]; m_tag[s][1] = t;
      for (int w = 0; w < 8; w++) begin
        d = m_data[s][0][w]; m_data[s][0][w] = m_data[s][1][w]; m_data[s][1][w] = d;
      end
    end
  endfunction

  always @(posedge clk) begin
    int s, idx, slot;
    if (rst === 1'b1) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else if (chk_en) begin
      s   = int'(Address[8:4]);
      idx = find(Address);
      if (Write_Enable) begin
        if (idx >= 0) begin
          m_data[s][idx][Address[3:1]] = Data_In;
          promote(s, idx);
        end else begin
          slot = (m_cnt[s] < 2) ? m_cnt[s] : 1;
          m_tag[s][slot] = Address[15:9];
          for (int w = 0; w < 8; w++) m_data[s][slot][w] = 16'h0000;
          m_data[s][slot][Address[3:1]] = Data_In;
          if (m_cnt[s] < 2) m_cnt[s]++;
          promote(s, slot);
        end
      end else if (idx >= 0) begin
        promote(s, idx);
      end
    end
  end

  always @(negedge clk) begin
    int          idx;
    logic        em;
    logic [15:0] ed;
    if (chk_en) begin
      idx = find(Address);
      em  = (idx < 0);
      ed  = em ? 16'h0000 : m_data[int'(Address[8:4])][idx][Address[3:1]];
      checks++;
      if (Miss !== em || Data_Out !== ed) begin
        failures++;
        $display("FAIL model addr=%h we=%b Miss=%b exp=%b Data_Out=%h exp=%h",
                 Address, Write_Enable, Miss, em, Data_Out, ed);
      end
    end
  end

  task automatic op(input logic [15:0] a, input logic we, input logic [15:0] d);
    Address = a; Write_Enable = we; Data_In = d;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input logic [15:0] a,
                     input logic em, input logic [15:0] ed);
    Address = a; Write_Enable = 1'b0; Data_In = 16'h0000;
    @(negedge clk); #1;
    checks++;
    if (Miss !== em || Data_Out !== ed) begin
      failures++;
      $display("FAIL %s addr=%h Miss=%b exp=%b Data_Out=%h exp=%h",
               name, a, Miss, em, Data_Out, ed);
    end
    @(posedge clk); #1;
  endtask

  localparam logic [15:0] RAND_ADDR [8] = '{16'h1812, 16'h0413, 16'h2412, 16'h1810,
                                            16'h1913, 16'h7E1E, 16'h001C, 16'h0012};

  initial begin
    rst = 1'b1; Write_Enable = 1'b0; Address = 16'h0000; Data_In = 16'h0000;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;

    lit("reset_read", 16'h0000, 1'b1, 16'h0000);
    lit("reset_read_hi", 16'hFFFE, 1'b1, 16'h0000);

    op(16'h1812, 1'b1, 16'h0001);
    op(16'h1913, 1'b1, 16'h0002);
    for (int i = 0; i < 4; i++) lit("hold_1812", 16'h1812, 1'b0, 16'h0001);
    for (int i = 0; i < 4; i++) lit("hold_1913", 16'h1913, 1'b0, 16'h0002);
    lit("bit0_ignored", 16'h1813, 1'b0, 16'h0001);

    lit("other_tag_miss", 16'h0413, 1'b1, 16'h0000);
    lit("after_miss_1812", 16'h1812, 1'b0, 16'h0001);

    lit("cleared_word", 16'h1810, 1'b0, 16'h0000);
    op(16'h1810, 1'b1, 16'hBEEF);
    lit("write_hit", 16'h1810, 1'b0, 16'hBEEF);
    lit("neighbour_word", 16'h1812, 1'b0, 16'h0001);

    op(16'h0413, 1'b1, 16'h0AAA);
    lit("touch_way0", 16'h1812, 1'b0, 16'h0001);
    op(16'h2412, 1'b1, 16'h0BBB);
    lit("evicted_0413", 16'h0413, 1'b1, 16'h0000);
    lit("kept_1812", 16'h1812, 1'b0, 16'h0001);
    lit("new_2412", 16'h2412, 1'b0, 16'h0BBB);
    lit("set17_intact", 16'h1913, 1'b0, 16'h0002);

    rst = 1'b1;
    op(16'h1812, 1'b1, 16'h5555);
    rst = 1'b0;
    lit("rst_beats_write", 16'h1812, 1'b1, 16'h0000);
    lit("rst_clears_1913", 16'h1913, 1'b1, 16'h0000);

    for (int i = 0; i < 300; i++)
      op(RAND_ADDR[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
         16'($urandom_range(0, 65535)));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_cache.md
I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock and reset ports are named clk and rst.
REQ-002 The block SHALL have a port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have a port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have a port Address, input, 16 bits: byte address; bit 0 is ignored (word-aligned access).
REQ-005 The block SHALL have a port Data_In, input, 16 bits: word to be written when Write_Enable=1.
REQ-006 The block SHALL have a port Write_Enable, input, 1 bit: 1 = write Data_In at Address on the next rising edge; 0 = read.
REQ-007 The block SHALL have a port Data_Out, output, 16 bits: word read at Address.
REQ-008 The block SHALL have a port Miss, output, 1 bit: 1 = Address not present in cache.

Function
REQ-009 Organisation SHALL be 2-way set-associative, 32 sets, 16-byte blocks of 8 16-bit words, 1 KB total.
REQ-010 Address decode SHALL be: word offset = Address[3:1], set index = Address[8:4], tag = Address[15:9] (7 bits).
REQ-011 Each way of each set SHALL hold one valid bit, a 7-bit tag and 8 data words; each set SHALL hold one LRU bit naming the least-recently-used way.
REQ-012 Hit SHALL be: either way in the indexed set is valid with a matching tag. At most one way may hit.
REQ-013 Miss SHALL be combinational from Address and current state: Miss = NOT hit, independent of Write_Enable.
REQ-014 Data_Out SHALL be combinational: the addressed word of the hitting way on a hit, 16'h0000 on a miss.
REQ-015 A read SHALL have zero-cycle latency and SHALL NOT modify data, tag or valid state.
REQ-016 A read hit SHALL set the set's LRU bit to the way not hit, updated at the rising edge.
REQ-017 A write hit (Write_Enable=1) SHALL replace the addressed word in the hitting way at the rising edge and SHALL set LRU to the other way.
REQ-018 A write miss SHALL allocate into the victim way at the rising edge: the first invalid way (way 0 before way 1), otherwise the LRU way.
REQ-019 On allocation, the block SHALL set valid, load the tag, write Data_In to the addressed word, clear the other 7 words to 16'h0000, and set LRU to the other way.
REQ-020 A write SHALL take effect on the rising edge; Data_Out/Miss for the same Address SHALL show the old contents until that edge and the new contents after it.
REQ-021 Writes and LRU updates to one set SHALL NOT affect any other set.
REQ-022 No other outputs or memory-side ports SHALL exist; miss handling (refill) is the responsibility of the surrounding controller, which issues writes.

Reset
REQ-023 When rst=1 at a rising edge, all valid bits and all LRU bits SHALL clear to 0; data and tag contents need not be cleared.
REQ-024 rst SHALL take priority over a simultaneous write; that write SHALL be discarded.
REQ-025 After reset, every address SHALL read Miss=1, Data_Out=16'h0000.

Verification
REQ-026 Reset, then read 0x0000 -> Miss=1, Data_Out=0x0000.
REQ-027 Write 0x0001 at 0x1812 (set 1, tag 0x0C), then write 0x0002 at 0x1913 (set 17), then read 0x1812 -> Miss=0, Data_Out=0x0001; read 0x1913 -> Miss=0, Data_Out=0x0002; each value holds steady over 4 idle cycles.
REQ-028 After REQ-027, read 0x0413 (set 1, tag 0x02) -> Miss=1, Data_Out=0x0000; then read 0x1812 -> still Miss=0, Data_Out=0x0001.
REQ-029 After REQ-027, read 0x1810 (same block, other word) -> Miss=0, Data_Out=0x0000 (cleared on allocate); write 0xBEEF at 0x1810, then read -> 0xBEEF, while 0x1812 still reads 0x0001.
REQ-030 Set-1 eviction: write 0x0AAA at 0x0413 (fills way 1), read 0x1812 (way 0 becomes MRU), write 0x0BBB at 0x2412 (tag 0x12) -> way 1 is evicted; 0x0413 misses, 0x1812 reads 0x0001, and 0x2412 reads 0x0BBB.
REQ-031 Assert rst together with Write_Enable=1 at 0x1812 -> after the edge, 0x1812 reads Miss=1, Data_Out=0x0000.
